width_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences the wide-write / narrow-read dual-port RAM for width conversion.
- Owns the write and read pointers, full/empty flags and fill level, and drives the RAM enables and addresses.
- Takes full RAM words back and emits one narrow slice per read accept.
- Sits between a wide producer and a narrow consumer; the RAM is instantiated alongside it at top level, with both RAM clocks tied to clk.

---
 rtl/width_fifo_pkg.sv | 27 ++
 rtl/width_fifo_ptr.sv | 52 +++++
 rtl/width_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_width_fifo_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/width_fifo_pkg.sv
// Shared helpers for the wide-write / narrow-read FIFO controller.
// Derives the width ratio, slice-index width and fill-level width from the port widths.
package width_fifo_pkg;

    // Number of narrow slices packed into one wide RAM word.
    function automatic int unsigned ratio_of(input int unsigned wr_w, input int unsigned rd_w);
        return wr_w / rd_w;
    endfunction

    // Bits needed to index a slice within a word (S).
    function automatic int unsigned slice_bits(input int unsigned wr_w, input int unsigned rd_w);
        return $clog2(wr_w / rd_w);
    endfunction

    // Width of the slice-granular fill level: ADDR_SIZE + S + 1.
    function automatic int unsigned level_width(input int unsigned addr_w,
                                                input int unsigned wr_w,
                                                input int unsigned rd_w);
        return addr_w + slice_bits(wr_w, rd_w) + 1;
    endfunction

    // Bit offset of slice idx inside a RAM word; slice 0 occupies the LSBs.
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned rd_w);
        return idx * rd_w;
    endfunction

endpackage

// File: rtl/width_fifo_ptr.sv
// Pointer bookkeeping for the width-converting FIFO.
// wptr counts words, rptr counts slices; both free-run with one extra MSB so full and
// empty are distinguishable. Flags and level are pure functions of the registered pointers.
module width_fifo_ptr
    import width_fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned S         = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wa,
    input  logic                   ra,
    output logic [ADDR_SIZE-1:0]   waddr,
    output logic [ADDR_SIZE-1:0]   raddr,
    output logic [S-1:0]           rslice,
    output logic [ADDR_SIZE+S:0]   level,
    output logic                   wr_full,
    output logic                   rd_empty
);

    localparam logic [ADDR_SIZE:0]   WONE    = 1;
    localparam logic [ADDR_SIZE+S:0] RONE    = 1;
    localparam logic [ADDR_SIZE:0]   DEPTH_W = {1'b1, {ADDR_SIZE{1'b0}}};

    logic [ADDR_SIZE:0]   wptr_q;
    logic [ADDR_SIZE+S:0] rptr_q;
    logic [ADDR_SIZE:0]   words_used;

    // Advance pointers on accepted transfers; reset discards all contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wa) wptr_q <= wptr_q + WONE;
            if (ra) rptr_q <= rptr_q + RONE;
        end
    end

    // A partially read word still counts as occupied, so compare against the word part of rptr.
    always_comb begin
        level      = {wptr_q, {S{1'b0}}} - rptr_q;
        words_used = wptr_q - rptr_q[ADDR_SIZE+S:S];
        wr_full    = (words_used == DEPTH_W);
        rd_empty   = (level == '0);
        waddr      = wptr_q[ADDR_SIZE-1:0];
        raddr      = rptr_q[ADDR_SIZE+S-1:S];
        rslice     = rptr_q[S-1:0];
    end

endmodule

// File: rtl/width_fifo_ctrl.sv
// Single-clock controller for a wide-write / narrow-read FIFO built on an external
// registered-output dual-port RAM. Emits one narrow slice per read accept, LSB slice first.
// Build option: define FIFO_ERR_FLAG_EN for sticky overflow/underflow flags; otherwise the
// ovf_err/udf_err ports are tied low.
module width_fifo_ctrl
    import width_fifo_pkg::*;
#(
    parameter int unsigned WRDATA_SIZE = 8,
    parameter int unsigned RDDATA_SIZE = 4,
    parameter int unsigned ADDR_SIZE   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_req,
    input  logic [WRDATA_SIZE-1:0] wr_data,
    output logic                   wr_full,
    input  logic                   rd_req,
    output logic [RDDATA_SIZE-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   rd_empty,
    output logic [level_width(ADDR_SIZE, WRDATA_SIZE, RDDATA_SIZE)-1:0] level,
    output logic                   ram_wren,
    output logic [ADDR_SIZE-1:0]   ram_waddr,
    output logic [WRDATA_SIZE-1:0] ram_wdata,
    output logic                   ram_rden,
    output logic [ADDR_SIZE-1:0]   ram_raddr,
    input  logic [WRDATA_SIZE-1:0] ram_rdata,
    output logic                   ovf_err,
    output logic                   udf_err
);

    localparam int unsigned S = slice_bits(WRDATA_SIZE, RDDATA_SIZE);

    logic                   wa;
    logic                   ra;
    logic [S-1:0]           rslice;
    logic [S-1:0]           rd_idx_q;
    logic                   rd_valid_q;
    logic [RDDATA_SIZE-1:0] rd_hold_q;
    logic [RDDATA_SIZE-1:0] slice_now;

    width_fifo_ptr #(
        .ADDR_SIZE (ADDR_SIZE),
        .S         (S)
    ) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .wa       (wa),
        .ra       (ra),
        .waddr    (ram_waddr),
        .raddr    (ram_raddr),
        .rslice   (rslice),
        .level    (level),
        .wr_full  (wr_full),
        .rd_empty (rd_empty)
    );

    // Accept gating on pre-edge flags; nothing reaches the RAM during reset.
    always_comb begin
        wa        = wr_req & ~wr_full & ~rst;
        ra        = rd_req & ~rd_empty & ~rst;
        ram_wren  = wa;
        ram_wdata = wr_data;
        ram_rden  = ra;
        slice_now = ram_rdata[slice_lsb(32'(rd_idx_q), RDDATA_SIZE) +: RDDATA_SIZE];
        rd_valid  = rd_valid_q;
        rd_data   = rd_valid_q ? slice_now : rd_hold_q;
    end

    // Track the slice index alongside the RAM read and keep the last delivered slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_hold_q  <= '0;
        end else begin
            rd_valid_q <= ra;
            if (ra) rd_idx_q <= rslice;
            if (rd_valid_q) rd_hold_q <= slice_now;
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    logic ovf_q;
    logic udf_q;

    // Sticky misuse flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_req & wr_full) ovf_q <= 1'b1;
            if (rd_req & rd_empty) udf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_width_fifo_ctrl.sv
// Directed/self-checking bench for width_fifo_ctrl (8-bit write, 4-bit read, 16 words).
// Includes a behavioural registered-output RAM and an independent pointer/scoreboard model.
module tb_width_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       wr_full;
    logic       rd_req;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       rd_empty;
    logic [5:0] level;
    logic       ram_wren;
    logic [3:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic       ram_rden;
    logic [3:0] ram_raddr;
    logic [7:0] ram_rdata;
    logic       ovf_err;
    logic       udf_err;

    width_fifo_ctrl #(
        .WRDATA_SIZE (8),
        .RDDATA_SIZE (4),
        .ADDR_SIZE   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_empty  (rd_empty),
        .level     (level),
        .ram_wren  (ram_wren),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_rden  (ram_rden),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .ovf_err   (ovf_err),
        .udf_err   (udf_err)
    );

    always #5 clk = ~clk;

    // Registered-output dual-port RAM, both ports on clk.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_waddr] <= ram_wdata;
        if (ram_rden) ram_rdata <= mem[ram_raddr];
    end

`ifdef FIFO_ERR_FLAG_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    int         mw = 0;       // model words written
    int         mr = 0;       // model slices read
    logic [3:0] sb [$];       // expected slices, oldest first
    logic [3:0] last_slice = 4'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_full();
        return (mw - mr / 2) == 16;
    endfunction

    function automatic logic m_empty();
        return (2 * mw) == mr;
    endfunction

    // One clock of stimulus with pre-edge flag/RAM checks and post-edge read-data checks.
    task automatic cycle(input logic wr, input logic [7:0] wd, input logic rd);
        logic exp_wa;
        logic exp_ra;
        wr_req  = wr;
        wr_data = wd;
        rd_req  = rd;
        #1;
        check("wr_full", {31'd0, wr_full}, {31'd0, m_full()});
        check("rd_empty", {31'd0, rd_empty}, {31'd0, m_empty()});
        check("level", {26'd0, level}, 32'(2 * mw - mr));
        exp_wa = wr & ~m_full();
        exp_ra = rd & ~m_empty();
        check("ram_wren", {31'd0, ram_wren}, {31'd0, exp_wa});
        check("ram_rden", {31'd0, ram_rden}, {31'd0, exp_ra});
        if (exp_wa) check("ram_waddr", {28'd0, ram_waddr}, 32'(mw % 16));
        if (exp_ra) check("ram_raddr", {28'd0, ram_raddr}, 32'((mr / 2) % 16));
        @(posedge clk);
        #1;
        if (exp_wa) begin
            sb.push_back(wd[3:0]);
            sb.push_back(wd[7:4]);
            mw++;
        end
        if (exp_ra) begin
            last_slice = sb.pop_front();
            mr++;
        end
        check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_ra});
        check("rd_data", {28'd0, rd_data}, {28'd0, last_slice});
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    // Reset with both requests high to show the RAM stays idle during rst.
    task automatic do_reset();
        rst    = 1'b1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        #1;
        check("rst_wren", {31'd0, ram_wren}, 32'd0);
        check("rst_rden", {31'd0, ram_rden}, 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        mw = 0;
        mr = 0;
        sb.delete();
        last_slice = 4'h0;
        check("rst_full", {31'd0, wr_full}, 32'd0);
        check("rst_empty", {31'd0, rd_empty}, 32'd1);
        check("rst_level", {26'd0, level}, 32'd0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_data", {28'd0, rd_data}, 32'd0);
        check("rst_ovf", {31'd0, ovf_err}, 32'd0);
        check("rst_udf", {31'd0, udf_err}, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && !m_empty(); i++) cycle(1'b0, 8'h00, 1'b1);
        check("drained_empty", {31'd0, rd_empty}, 32'd1);
    endtask

    initial begin
        rst     = 1'b1;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single word, two slices, LSB first.
        cycle(1'b1, 8'hA5, 1'b0);
        check("t2_level2", {26'd0, level}, 32'd2);
        check("t2_not_empty", {31'd0, rd_empty}, 32'd0);
        cycle(1'b0, 8'h00, 1'b1);
        check("t2_slice0", {28'd0, rd_data}, 32'h5);
        check("t2_level1", {26'd0, level}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        check("t2_slice1", {28'd0, rd_data}, 32'hA);
        check("t2_level0", {26'd0, level}, 32'd0);
        check("t2_empty", {31'd0, rd_empty}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0);
        check("t2_hold", {28'd0, rd_data}, 32'hA);

        // Fill to full, reject a 17th write, free a word only after its second slice.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
        check("t3_full", {31'd0, wr_full}, 32'd1);
        check("t3_level32", {26'd0, level}, 32'd32);
        cycle(1'b1, 8'hFF, 1'b0);
        check("t3_level_hold", {26'd0, level}, 32'd32);
        cycle(1'b0, 8'h00, 1'b1);
        check("t3_first_slice", {28'd0, rd_data}, 32'h0);
        check("t3_still_full", {31'd0, wr_full}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        check("t3_second_slice", {28'd0, rd_data}, 32'h3);
        check("t3_not_full", {31'd0, wr_full}, 32'd0);
        drain();

        // Concurrent write and read every cycle from one word.
        cycle(1'b1, 8'h12, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h40 + 3 * i), 1'b1);
        drain();

        // Random stream of 100 words with random gaps.
        begin
            int target;
            target = mw + 100;
            for (int i = 0; i < 4000 && mw < target; i++) begin
                cycle(($urandom_range(0, 3) != 0) && (mw < target), 8'($urandom),
                      $urandom_range(0, 2) != 0);
            end
            check("t5_words", 32'(mw), 32'(target));
        end
        drain();

        // Error flags, then reset mid-stream at level 9.
        do_reset();
        cycle(1'b0, 8'h00, 1'b1);
        check("t6_udf", {31'd0, udf_err}, {31'd0, ERR_ON});
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b0);
        check("t6_ovf", {31'd0, ovf_err}, {31'd0, ERR_ON});
        for (int i = 0; i < 23; i++) cycle(1'b0, 8'h00, 1'b1);
        check("t6_level9", {26'd0, level}, 32'd9);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
